// File: rtl/mmio_pkg.sv
// Shared address map and STATUS bit layout for the memory-mapped responder.
package mmio_pkg;

  localparam logic [7:0] IO_BASE     = 8'hF0;
  localparam logic [7:0] ADDR_SW     = 8'hF0;
  localparam logic [7:0] ADDR_LED    = 8'hF1;
  localparam logic [7:0] ADDR_TIMER  = 8'hF2;
  localparam logic [7:0] ADDR_OUT    = 8'hF3;
  localparam logic [7:0] ADDR_STATUS = 8'hF4;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERFLOW = 2;

endpackage

// File: rtl/out_fifo.sv
// Circular-buffer output FIFO; the head is presented from storage, so there is no fall-through.
module out_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic [15:0] head,
  output logic        empty,
  output logic        full,
  output logic        drop
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [15:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_pop_s;
  logic          do_push_s;

  // A push into a full FIFO still fits when the head leaves in the same cycle.
  always_comb begin
    empty     = (count_r == {CW{1'b0}});
    full      = (count_r == DEPTH_C);
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    drop      = push && !do_push_s;
    if (empty) begin
      head = 16'h0000;
    end else begin
      head = mem_r[rd_ptr_r];
    end
  end

  // Storage; stale words are harmless because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + 1'b1;
      end else if (do_pop_s && !do_push_s) begin
        count_r <= count_r - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// CPU-side memory responder: 240-word RAM plus an I/O page (switches, LEDs, timer, output FIFO)
// with a one-cycle registered read path.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_w_en,
  input  logic [7:0]  ram_addr,
  input  logic [15:0] ram_w_data,
  output logic [15:0] ram_r_data,
  input  logic [9:0]  sw,
  output logic [9:0]  led,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [7:0] RAM_LIMIT = 8'(RAM_WORDS);

  logic [15:0] ram_r [RAM_WORDS];
  logic [9:0]  sw_q_r;
  logic [15:0] timer_r;
  logic        overflow_r;

  logic        is_ram_s;
  logic        ram_we_s;
  logic        led_we_s;
  logic        timer_we_s;
  logic        push_s;
  logic        status_we_s;
  logic        pop_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        fifo_drop_s;
  logic [15:0] fifo_head_s;
  logic [15:0] status_s;
  logic [15:0] rd_mux_s;

  // Write decode for the RAM window and the I/O page.
  always_comb begin
    is_ram_s    = (ram_addr < RAM_LIMIT);
    ram_we_s    = ram_w_en && is_ram_s;
    led_we_s    = ram_w_en && (ram_addr == ADDR_LED);
    timer_we_s  = ram_w_en && (ram_addr == ADDR_TIMER);
    push_s      = ram_w_en && (ram_addr == ADDR_OUT);
    status_we_s = ram_w_en && (ram_addr == ADDR_STATUS);
    pop_s       = out_ready && !fifo_empty_s;
  end

  out_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (ram_w_data),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s),
    .drop      (fifo_drop_s)
  );

  assign out_data  = fifo_head_s;
  assign out_valid = !fifo_empty_s;

  // Read mux over pre-edge state; registering it gives read-old-data on same-address writes.
  always_comb begin
    status_s                = 16'h0000;
    status_s[STAT_EMPTY]    = fifo_empty_s;
    status_s[STAT_FULL]     = fifo_full_s;
    status_s[STAT_OVERFLOW] = overflow_r;
    if (is_ram_s) begin
      rd_mux_s = ram_r[ram_addr];
    end else begin
      case (ram_addr)
        ADDR_SW:     rd_mux_s = {6'b000000, sw_q_r};
        ADDR_LED:    rd_mux_s = {6'b000000, led};
        ADDR_TIMER:  rd_mux_s = timer_r;
        ADDR_STATUS: rd_mux_s = status_s;
        default:     rd_mux_s = 16'h0000;
      endcase
    end
  end

  // RAM keeps its contents across reset, but a write coinciding with reset is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      if (ram_we_s) begin
        ram_r[ram_addr] <= ram_w_data;
      end
    end
  end

  // Read data, switch sampling, LED, timer and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_r_data <= 16'h0000;
      sw_q_r     <= 10'h000;
      led        <= 10'h000;
      timer_r    <= 16'h0000;
      overflow_r <= 1'b0;
    end else begin
      ram_r_data <= rd_mux_s;
      sw_q_r     <= sw;
      if (led_we_s) begin
        led <= ram_w_data[9:0];
      end
      if (timer_we_s) begin
        timer_r <= ram_w_data;
      end else begin
        timer_r <= timer_r + 16'h0001;
      end
      // A new drop outranks a clear request in the same cycle.
      if (fifo_drop_s) begin
        overflow_r <= 1'b1;
      end else if (status_we_s && ram_w_data[STAT_OVERFLOW]) begin
        overflow_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-side responder for the 8-bit-address, 16-bit-data CPU memory interface: it answers every CPU access with one-cycle registered read latency. It combines a 240-word program/data RAM with a page of memory-mapped I/O at 0xF0–0xFF: switches, LEDs, a free-running timer and a 4-entry output FIFO. The FIFO is drained by an external consumer over a valid/ready handshake. It drops in where the plain RAM sits beside the CPU, using the same port names.

## Interface
Parameters:
- RAM_WORDS, 240: RAM depth, addresses 0x00–0xEF.
- FIFO_DEPTH, 4: output FIFO depth; power of two.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous reset, active-high.
- ram_w_en  in  1  write strobe for the current address.
- ram_addr  in  8  shared read/write address.
- ram_w_data  in  16  write data.
- ram_r_data  out  16  registered read data.
- sw  in  10  switch inputs; sampled once per cycle.
- led  out  10  LED register.
- out_data  out  16  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word when out_valid && out_ready.

## Operation
- Every cycle is an access. There is no request strobe.
  - Reads happen unconditionally, including during writes.
  - Writes happen only when ram_w_en is high.
- Address map:
  - 0x00–0xEF RAM:
    - Write stores ram_w_data.
    - Read during write to the same address returns the old word.
    - Contents are not cleared by reset.
  - 0xF0 SW: read returns {6'b0, sw_q}, where sw_q is sw registered one cycle. Writes are ignored.
  - 0xF1 LED:
    - Write sets led to ram_w_data[9:0].
    - Read returns {6'b0, led}.
  - 0xF2 TIMER: 16-bit counter.
    - Increments by 1 every cycle and wraps 0xFFFF→0x0000.
    - Write loads ram_w_data, overriding that cycle's increment.
    - Read returns the pre-edge value.
  - 0xF3 OUT:
    - Write pushes ram_w_data into the FIFO.
    - Read returns 0x0000 and has no side effect.
  - 0xF4 STATUS:
    - Read returns {13'b0, overflow, full, empty}.
    - Write with ram_w_data[2]=1 clears overflow. Other bits are ignored.
  - 0xF5–0xFF: read 0x0000; writes ignored.
- FIFO:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped, contents are unchanged, and overflow is set. Overflow is sticky.
  - A pop while empty is impossible, because out_valid=0.
  - Push and pop in the same cycle leave count unchanged; the order is preserved.
  - An overflow set and a STATUS clear in the same cycle: set wins.
- Outputs after rst:
  - ram_r_data=0, led=0, timer=0, sw_q=0.
  - FIFO empty: out_valid=0, out_data=0.
  - overflow=0.
- Reset mid-operation:
  - FIFO contents are discarded immediately.
  - Any in-flight write in the reset cycle is lost.
  - RAM is retained.

## Timing
- Read latency is 1: the address presented before edge N appears on ram_r_data after edge N and holds until the next edge. This matches the CPU fetch/decode state timing.
- Write takes effect at the same edge; a read of that address in the next cycle returns the new value.
- Timer read of value T at edge N, followed by a write of V at edge N+1, gives V at N+2 and V+1 at N+3.
- out_valid rises the cycle after the first accepted push; there is no fall-through. out_data is the head register, stable while out_valid && !out_ready.
- Status flags reflect pre-edge FIFO state.

## Structure
- Package mmio_pkg holds:
  - address constants ADDR_SW=8'hF0, ADDR_LED=8'hF1, ADDR_TIMER=8'hF2, ADDR_OUT=8'hF3, ADDR_STATUS=8'hF4, IO_BASE=8'hF0;
  - the STATUS bit indices.
- Sub-module out_fifo (parameter FIFO_DEPTH):
  - circular buffer with rd/wr pointers and a count of width $clog2(FIFO_DEPTH)+1;
  - ports push, push_data, pop, head, empty, full, drop.
- Top level: address decode, RAM array, registered read mux, LED/timer/sw_q/overflow registers.

## Test plan
- Reset then a RAM write/readback:
  - Assert rst mid-run → all outputs match the reset values listed under Operation.
  - Write 0x1234 to 0x05, read 0x05 → ram_r_data=0x1234 one cycle later.
  - RAM contents survive a second rst pulse.
- Read-during-write: 0x20 holds 0xAAAA; write 0x5555 to 0x20 with the same address held → first read returns 0xAAAA, next cycle returns 0x5555.
- LED/SW:
  - Write 0x03FF to 0xF1 → led=10'h3FF.
  - sw=10'h155 held, read 0xF0 → 0x0155.
  - Write to 0xF0 → no effect.
- Timer:
  - Write 0xFFFE to 0xF2, wait 2 cycles, read → wraps through 0x0000; value read equals the cycle-counted expectation.
- FIFO fill and overflow:
  - With out_ready=0, push 1,2,3,4,5 → STATUS=0b010 after the 4th push and 0b110 after the 5th.
  - Then hold out_ready=1 → out_data sequence 1,2,3,4; out_valid falls; STATUS=0b101.
  - Write 0x0004 to 0xF4 → STATUS=0b001.
- Full push/pop: FIFO full, out_ready=1 and a push of 9 in the same cycle → no overflow, count stays 4, 9 emerges last.
